// File: rtl/axis_flit_ejector.sv
// axis_flit_ejector: credit-based NoC flit sink that buffers flits and reassembles them into AXI-Stream beats
module axis_flit_ejector #(
    parameter int FLIT_WIDTH = 64,
    parameter int TID_WIDTH = 2,
    parameter int TDEST_WIDTH = 4,
    parameter int DEST_WIDTH = TID_WIDTH + TDEST_WIDTH,
    parameter int SERIALIZATION_FACTOR = 1,
    parameter int FLIT_BUFFER_DEPTH = 2,
    parameter int TDATA_WIDTH = FLIT_WIDTH * SERIALIZATION_FACTOR
) (
    input  logic                   clk_noc,
    input  logic                   rst_noc,
    input  logic [FLIT_WIDTH-1:0]  data_in,
    input  logic [DEST_WIDTH-1:0]  dest_in,
    input  logic                   is_tail_in,
    input  logic                   send_in,
    output logic                   credit_out,
    output logic                   axis_out_tvalid,
    input  logic                   axis_out_tready,
    output logic [TDATA_WIDTH-1:0] axis_out_tdata,
    output logic                   axis_out_tlast,
    output logic [TID_WIDTH-1:0]   axis_out_tid,
    output logic [TDEST_WIDTH-1:0] axis_out_tdest,
    output logic                   overflow_err
);
    localparam int CW = SERIALIZATION_FACTOR > 1 ? $clog2(SERIALIZATION_FACTOR) : 1;
    localparam int AW = FLIT_BUFFER_DEPTH > 1 ? $clog2(FLIT_BUFFER_DEPTH) : 1;
    localparam int NW = $clog2(FLIT_BUFFER_DEPTH + 1);
    localparam logic [CW-1:0] LAST_LANE = CW'(SERIALIZATION_FACTOR - 1);
    localparam logic [AW-1:0] LAST_SLOT = AW'(FLIT_BUFFER_DEPTH - 1);
    localparam logic [NW-1:0] DEPTH = NW'(FLIT_BUFFER_DEPTH);

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t                 state;
    logic [FLIT_WIDTH-1:0]  mem_data [FLIT_BUFFER_DEPTH];
    logic [DEST_WIDTH-1:0]  mem_dest [FLIT_BUFFER_DEPTH];
    logic                   mem_tail [FLIT_BUFFER_DEPTH];
    logic [AW-1:0]          rd_ptr, wr_ptr;
    logic [NW-1:0]          count;
    logic [CW-1:0]          cnt;
    logic                   empty, full, pop, push, done;
    logic [TDATA_WIDTH-1:0] asm_next;

    // Lane 0 starts a fresh beat, so every higher lane is cleared for early tails.
    always_comb begin
        empty = count == '0;
        full = count == DEPTH;
        pop = !empty && (state == COLLECT || axis_out_tready);
        push = send_in && (!full || pop);
        done = mem_tail[rd_ptr] || cnt == LAST_LANE;
        asm_next = cnt == '0 ? '0 : axis_out_tdata;
        asm_next[int'(cnt) * FLIT_WIDTH +: FLIT_WIDTH] = mem_data[rd_ptr];
    end

    always_ff @(posedge clk_noc) begin
        if (push) begin
            mem_data[wr_ptr] <= data_in;
            mem_dest[wr_ptr] <= dest_in;
            mem_tail[wr_ptr] <= is_tail_in;
        end
    end

    always_ff @(posedge clk_noc or posedge rst_noc) begin
        if (rst_noc) begin
            state <= COLLECT;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            cnt <= '0;
            credit_out <= 1'b0;
            overflow_err <= 1'b0;
            axis_out_tvalid <= 1'b0;
            axis_out_tdata <= '0;
            axis_out_tlast <= 1'b0;
            axis_out_tid <= '0;
            axis_out_tdest <= '0;
        end else begin
            credit_out <= pop;
            count <= count + NW'(push) - NW'(pop);
            if (send_in && full && !pop) overflow_err <= 1'b1;
            if (push) wr_ptr <= wr_ptr == LAST_SLOT ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr == LAST_SLOT ? '0 : rd_ptr + 1'b1;
            if (state == HOLD && axis_out_tready) begin
                state <= COLLECT;
                axis_out_tvalid <= 1'b0;
            end
            // A pop during a HOLD handshake overrides the return to COLLECT when it completes a beat.
            if (pop) begin
                axis_out_tdata <= asm_next;
                if (cnt == '0) {axis_out_tid, axis_out_tdest} <= mem_dest[rd_ptr];
                if (done) begin
                    state <= HOLD;
                    axis_out_tvalid <= 1'b1;
                    axis_out_tlast <= mem_tail[rd_ptr];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_axis_flit_ejector.sv
// tb_axis_flit_ejector: directed and randomized checks of two ejector instances (SF=1, SF=4) against a beat-level model
module tb_axis_flit_ejector;
    typedef struct packed {
        logic [255:0] data;
        logic         last;
        logic [5:0]   dest;
    } beat_t;

    logic         clk_noc = 1'b0;
    logic         rst_noc = 1'b1;
    logic [63:0]  data_in [2];
    logic [5:0]   dest_in [2];
    logic         is_tail_in [2];
    logic         send_in [2];
    logic         tready [2];
    logic         credit_out [2];
    logic         tvalid [2];
    logic         tlast [2];
    logic         ovf [2];
    logic [1:0]   tid [2];
    logic [3:0]   tdest [2];
    logic [63:0]  tdata0;
    logic [255:0] tdata1;

    int           pass_cnt = 0;
    int           total_cnt = 0;
    int           credits [2];
    int           pulses [2];
    int           lane [2];
    logic         ovf_exp [2];
    logic         prev_hold [2];
    beat_t        prev_beat [2];
    logic [255:0] part_data [2];
    logic [5:0]   part_dest [2];
    beat_t        q0 [$];
    beat_t        q1 [$];

    always #5 clk_noc = ~clk_noc;

    axis_flit_ejector u_sf1 (
        .clk_noc(clk_noc), .rst_noc(rst_noc),
        .data_in(data_in[0]), .dest_in(dest_in[0]), .is_tail_in(is_tail_in[0]), .send_in(send_in[0]),
        .credit_out(credit_out[0]), .axis_out_tvalid(tvalid[0]), .axis_out_tready(tready[0]),
        .axis_out_tdata(tdata0), .axis_out_tlast(tlast[0]), .axis_out_tid(tid[0]),
        .axis_out_tdest(tdest[0]), .overflow_err(ovf[0])
    );

    axis_flit_ejector #(.SERIALIZATION_FACTOR(4)) u_sf4 (
        .clk_noc(clk_noc), .rst_noc(rst_noc),
        .data_in(data_in[1]), .dest_in(dest_in[1]), .is_tail_in(is_tail_in[1]), .send_in(send_in[1]),
        .credit_out(credit_out[1]), .axis_out_tvalid(tvalid[1]), .axis_out_tready(tready[1]),
        .axis_out_tdata(tdata1), .axis_out_tlast(tlast[1]), .axis_out_tid(tid[1]),
        .axis_out_tdest(tdest[1]), .overflow_err(ovf[1])
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: flits fill lanes from the LSB; a beat closes on a tail or the last lane.
    task automatic add_flit(input int i, input logic [63:0] d, input logic [5:0] dst, input logic tl);
        beat_t b;
        int sf = i == 0 ? 1 : 4;
        if (lane[i] == 0) begin
            part_data[i] = '0;
            part_dest[i] = dst;
        end
        part_data[i][lane[i] * 64 +: 64] = d;
        if (tl || lane[i] == sf - 1) begin
            b.data = part_data[i];
            b.last = tl;
            b.dest = part_dest[i];
            if (i == 0) q0.push_back(b);
            else q1.push_back(b);
            lane[i] = 0;
        end else begin
            lane[i]++;
        end
    endtask

    task automatic mon(input int i);
        beat_t b, e;
        int sz;
        b.data = i == 0 ? 256'(tdata0) : tdata1;
        b.last = tlast[i];
        b.dest = {tid[i], tdest[i]};
        if (prev_hold[i]) begin
            check("tvalid_held", tvalid[i], 1);
            check("hold_data", b.data, prev_beat[i].data);
            check("hold_ctl", {b.last, b.dest}, {prev_beat[i].last, prev_beat[i].dest});
        end
        if (tvalid[i] && tready[i]) begin
            sz = i == 0 ? q0.size() : q1.size();
            check("beat_expected", sz > 0, 1);
            if (sz > 0) begin
                if (i == 0) e = q0.pop_front();
                else e = q1.pop_front();
                check("beat_data", b.data, e.data);
                check("beat_ctl", {b.last, b.dest}, {e.last, e.dest});
            end
        end
        prev_hold[i] = tvalid[i] && !tready[i];
        prev_beat[i] = b;
        if (credit_out[i]) begin
            credits[i]++;
            pulses[i]++;
        end
        check("overflow_flag", ovf[i], ovf_exp[i]);
    endtask

    always @(negedge clk_noc) begin
        if (!rst_noc) begin
            mon(0);
            mon(1);
        end
    end

    task automatic do_reset();
        rst_noc = 1'b1;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            credits[i] = 2;
            pulses[i] = 0;
            lane[i] = 0;
            ovf_exp[i] = 1'b0;
            prev_hold[i] = 1'b0;
        end
        repeat (2) @(posedge clk_noc);
        #1 rst_noc = 1'b0;
    endtask

    task automatic send_flit(input int i, input logic [63:0] d, input logic [5:0] dst, input logic tl, input bit acc);
        data_in[i] = d;
        dest_in[i] = dst;
        is_tail_in[i] = tl;
        send_in[i] = 1'b1;
        credits[i]--;
        if (acc) add_flit(i, d, dst, tl);
        @(posedge clk_noc);
        #1 send_in[i] = 1'b0;
    endtask

    task automatic wait_valid(input int i, input int lim);
        int n = 0;
        while (!tvalid[i] && n < lim) begin
            @(negedge clk_noc);
            n++;
        end
        check("valid_within_bound", tvalid[i], 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int p, n;
        for (int i = 0; i < 2; i++) begin
            send_in[i] = 1'b0;
            data_in[i] = '0;
            dest_in[i] = '0;
            is_tail_in[i] = 1'b0;
            tready[i] = 1'b1;
        end
        do_reset();
        check("reset_state", {tvalid[0], tvalid[1], credit_out[0], credit_out[1], ovf[0], ovf[1]}, 0);

        send_flit(0, 64'hDEADBEEF, 6'b10_0011, 1'b1, 1'b1);
        @(negedge clk_noc);
        check("t1_valid_early", tvalid[0], 0);
        @(negedge clk_noc);
        check("t1_valid", tvalid[0], 1);
        check("t1_data", tdata0, 64'hDEADBEEF);
        check("t1_tid", tid[0], 2);
        check("t1_tdest", tdest[0], 3);
        check("t1_last", tlast[0], 1);
        check("t1_credit", credit_out[0], 1);
        @(negedge clk_noc);
        check("t1_credit_once", credit_out[0], 0);
        check("t1_valid_done", tvalid[0], 0);

        @(posedge clk_noc);
        #1 p = pulses[1];
        for (int k = 1; k <= 4; k++) send_flit(1, 64'(k), 6'b01_0101, k == 4, 1'b1);
        @(negedge clk_noc);
        check("t2_valid_early", tvalid[1], 0);
        @(negedge clk_noc);
        check("t2_valid", tvalid[1], 1);
        check("t2_data", tdata1, {64'h4, 64'h3, 64'h2, 64'h1});
        check("t2_last", tlast[1], 1);
        check("t2_dest", {tid[1], tdest[1]}, 6'b01_0101);
        repeat (3) @(posedge clk_noc);
        #1 check("t2_credits", pulses[1] - p, 4);

        send_flit(1, 64'hA, 6'b11_0001, 1'b0, 1'b1);
        send_flit(1, 64'hB, 6'b00_0000, 1'b1, 1'b1);
        wait_valid(1, 6);
        check("t3_data", tdata1, {128'h0, 64'hB, 64'hA});
        check("t3_last", tlast[1], 1);
        check("t3_dest", {tid[1], tdest[1]}, 6'b11_0001);
        @(posedge clk_noc);
        #1 send_flit(1, 64'h11, 6'b00_0010, 1'b1, 1'b1);
        wait_valid(1, 6);
        check("t3_next_lane0", tdata1, 256'h11);

        @(posedge clk_noc);
        #1 tready[0] = 1'b0;
        p = pulses[0];
        n = 0;
        repeat (10) begin
            if (credits[0] > 0) begin
                send_flit(0, 64'h100 + 64'(n), 6'(n), 1'b1, 1'b1);
                n++;
            end else begin
                @(posedge clk_noc);
                #1;
            end
        end
        check("bp_sent", n, 3);
        check("bp_credits", pulses[0] - p, 1);
        check("bp_valid", tvalid[0], 1);
        check("bp_data", tdata0, 64'h100);
        tready[0] = 1'b1;
        repeat (8) @(posedge clk_noc);
        #1 check("bp_drained", q0.size(), 0);
        check("bp_credits_back", credits[0], 2);

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                tready[i] = ($urandom % 4) != 0;
                if (credits[i] > 0 && ($urandom % 3) != 0) begin
                    data_in[i] = {$urandom, $urandom};
                    dest_in[i] = 6'($urandom);
                    is_tail_in[i] = ($urandom % 3) == 0;
                    send_in[i] = 1'b1;
                    credits[i]--;
                    add_flit(i, data_in[i], dest_in[i], is_tail_in[i]);
                end else begin
                    send_in[i] = 1'b0;
                end
            end
            @(posedge clk_noc);
            #1;
        end
        for (int i = 0; i < 2; i++) begin
            send_in[i] = 1'b0;
            tready[i] = 1'b1;
        end
        repeat (20) @(posedge clk_noc);
        #1 check("rnd_drained_sf1", q0.size(), 0);
        check("rnd_drained_sf4", q1.size(), 0);
        check("rnd_credits_sf1", credits[0], 2);
        check("rnd_credits_sf4", credits[1], 2);

        do_reset();
        send_flit(1, 64'h21, 6'h05, 1'b0, 1'b1);
        send_flit(1, 64'h22, 6'h05, 1'b0, 1'b1);
        @(posedge clk_noc);
        #3 rst_noc = 1'b1;
        #1 check("rst_valid", {tvalid[0], tvalid[1]}, 0);
        check("rst_data", {|tdata0, |tdata1}, 0);
        check("rst_ctl", {tlast[0], tlast[1], tid[0], tid[1], tdest[0], tdest[1]}, 0);
        check("rst_credit_ovf", {credit_out[0], credit_out[1], ovf[0], ovf[1]}, 0);
        do_reset();
        for (int k = 1; k <= 4; k++) send_flit(1, 64'h30 + 64'(k), 6'h2A, k == 4, 1'b1);
        wait_valid(1, 8);
        check("rst_new_beat", tdata1, {64'h34, 64'h33, 64'h32, 64'h31});
        check("rst_new_dest", {tid[1], tdest[1]}, 6'h2A);

        @(posedge clk_noc);
        #1 do_reset();
        tready[0] = 1'b0;
        send_flit(0, 64'h51, 6'h01, 1'b1, 1'b1);
        repeat (2) @(posedge clk_noc);
        #1 p = pulses[0];
        send_flit(0, 64'h52, 6'h02, 1'b1, 1'b1);
        send_flit(0, 64'h53, 6'h03, 1'b1, 1'b1);
        check("ovf_before", ovf[0], 0);
        send_flit(0, 64'h54, 6'h04, 1'b1, 1'b0);
        ovf_exp[0] = 1'b1;
        check("ovf_set", ovf[0], 1);
        repeat (3) @(posedge clk_noc);
        #1 check("ovf_no_credit", pulses[0] - p, 0);
        tready[0] = 1'b1;
        repeat (10) @(posedge clk_noc);
        #1 check("ovf_drained", q0.size(), 0);
        check("ovf_credit_total", pulses[0], 3);
        check("ovf_sticky", ovf[0], 1);
        do_reset();
        check("ovf_cleared", ovf[0], 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
